// File: rtl/mips_boot_loader.sv
// Byte-serial framed program loader for the MIPS instruction memory.
// Holds the core in reset until a complete image with a matching XOR checksum has been written.
module mips_boot_loader #(
    parameter int unsigned ADDR_W      = 6,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              ImWe,
    output logic [ADDR_W-1:0] ImWrAdr,
    output logic [31:0]       ImWrData,
    output logic              CpuReset,
    output logic              Done,
    output logic              Err
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_SYNC, S_COUNT, S_DATA, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_data;
    logic [7:0]        r_chk;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_err;

    logic w_accept;
    logic w_in_frame;
    logic w_tmo_fire;
    logic w_n_legal;
    logic w_word_done;
    logic w_last_word;
    logic w_chk_ok;
    logic w_we_nxt;
    logic w_done_nxt;
    logic w_err_nxt;

    assign w_in_frame  = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign w_accept    = rx_valid && rx_ready;
    // An accepted byte on the expiry edge wins over the timeout.
    assign w_tmo_fire  = w_in_frame && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_n_legal   = (rx_byte != 8'd0) && (32'(rx_byte) <= MAX_WORDS);
    assign w_word_done = (r_bcnt == 2'd3);
    assign w_last_word = (r_idx == r_last);
    assign w_chk_ok    = (rx_byte == r_chk);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_SYNC;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  if (w_accept && (rx_byte == SYNC_BYTE)) w_state_nxt = S_COUNT;
            S_COUNT: begin
                if (w_accept)        w_state_nxt = w_n_legal ? S_DATA : S_ERROR;
                else if (w_tmo_fire) w_state_nxt = S_SYNC;
            end
            S_DATA: begin
                if (w_accept && w_word_done && w_last_word) w_state_nxt = S_CHECK;
                else if (w_tmo_fire)                        w_state_nxt = S_SYNC;
            end
            S_CHECK: begin
                if (w_accept)        w_state_nxt = w_chk_ok ? S_RUN : S_ERROR;
                else if (w_tmo_fire) w_state_nxt = S_SYNC;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Output logic: live handshake plus next values of the registered outputs
    always_comb begin
        rx_ready   = 1'b0;
        w_we_nxt   = 1'b0;
        w_done_nxt = r_done;
        w_err_nxt  = r_err;
        if (!Reset) rx_ready = (r_state == S_SYNC) || w_in_frame;
        case (r_state)
            S_COUNT: if (w_accept && !w_n_legal) w_err_nxt = 1'b1;
            S_DATA:  if (w_accept && w_word_done) w_we_nxt = 1'b1;
            S_CHECK: begin
                if (w_accept && w_chk_ok)  w_done_nxt = 1'b1;
                if (w_accept && !w_chk_ok) w_err_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: word assembly, checksum, index and idle timer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_idx       <= '0;
            r_last      <= '0;
            r_bcnt      <= '0;
            r_data      <= '0;
            r_chk       <= '0;
            r_tmo       <= '0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we        <= w_we_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_cpu_reset <= !w_done_nxt;
            if (w_we_nxt) begin
                r_adr   <= r_idx;
                r_wdata <= {r_data, rx_byte};
            end
            if (!w_in_frame || w_accept || w_tmo_fire) r_tmo <= '0;
            else                                       r_tmo <= r_tmo + TMO_W'(1);
            if (w_tmo_fire) begin
                r_idx  <= '0;
                r_bcnt <= '0;
                r_chk  <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_COUNT: begin
                        r_chk  <= rx_byte;
                        r_last <= ADDR_W'(32'(rx_byte) - 32'd1);
                        r_idx  <= '0;
                        r_bcnt <= '0;
                    end
                    S_DATA: begin
                        r_data <= {r_data[15:0], rx_byte};
                        r_chk  <= r_chk ^ rx_byte;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_word_done) r_idx <= r_idx + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ImWe     = r_we;
    assign ImWrAdr  = r_adr;
    assign ImWrData = r_wdata;
    assign CpuReset = r_cpu_reset;
    assign Done     = r_done;
    assign Err      = r_err;

endmodule
